// File: rtl/wvb_occupancy_monitor_pkg.sv
// Shared widths and helpers for the waveform-buffer occupancy monitor.
// The same word widths are used by the readout register maps.
package wvb_occupancy_monitor_pkg;

  localparam int L_WVB_WUSED_WIDTH = 16;
  localparam int L_OVF_CNT_WIDTH   = 16;

  typedef logic [L_WVB_WUSED_WIDTH-1:0] wused_t;
  typedef logic [L_OVF_CNT_WIDTH-1:0]   ovf_cnt_t;

  function automatic wused_t wused_max(input wused_t a, input wused_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/wvb_occupancy_monitor_if.sv
// Bundle of per-channel buffer/readout signals seen by the occupancy monitor.
// Channel i of each packed vector sits at [i*width +: width].
interface wvb_occupancy_monitor_if
  import wvb_occupancy_monitor_pkg::*;
#(
  parameter int P_N_CHAN    = 8,
  parameter int P_ADR_WIDTH = 12
) ();

  logic [P_N_CHAN*P_ADR_WIDTH-1:0]       wvb_wr_addr;
  logic [P_N_CHAN*P_ADR_WIDTH-1:0]       stop_addr;
  logic [P_N_CHAN-1:0]                   wvb_rddone;
  logic [P_N_CHAN-1:0]                   hdr_full;
  wused_t                                af_thresh;
  logic                                  stat_clr;

  logic [P_N_CHAN-1:0]                   overflow;
  logic                                  overflow_any;
  logic [P_N_CHAN*L_WVB_WUSED_WIDTH-1:0] wvb_wused;
  logic [P_N_CHAN-1:0]                   almost_full;
  logic                                  almost_full_any;
  logic [P_N_CHAN-1:0]                   ovf_sticky;
  logic [P_N_CHAN*L_OVF_CNT_WIDTH-1:0]   ovf_cnt;
  logic [P_N_CHAN*L_WVB_WUSED_WIDTH-1:0] hwm;

  modport master (
    output wvb_wr_addr, stop_addr, wvb_rddone, hdr_full, af_thresh, stat_clr,
    input  overflow, overflow_any, wvb_wused, almost_full, almost_full_any,
           ovf_sticky, ovf_cnt, hwm
  );

  modport slave (
    input  wvb_wr_addr, stop_addr, wvb_rddone, hdr_full, af_thresh, stat_clr,
    output overflow, overflow_any, wvb_wused, almost_full, almost_full_any,
           ovf_sticky, ovf_cnt, hwm
  );

endinterface

// File: rtl/wvb_occupancy_chan.sv
// Per-channel occupancy logic: read pointer, words used, almost-full and
// overflow statistics (sticky flag, saturating event count, high-water mark).
module wvb_occupancy_chan
  import wvb_occupancy_monitor_pkg::*;
#(
  parameter int P_ADR_WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [P_ADR_WIDTH-1:0] wr_addr,
  input  logic [P_ADR_WIDTH-1:0] stop_addr,
  input  logic                   rddone,
  input  logic                   hdr_full,
  input  wused_t                 af_thresh,
  input  logic                   stat_clr,
  output logic                   overflow,
  output wused_t                 wused,
  output logic                   almost_full,
  output logic                   ovf_sticky,
  output ovf_cnt_t               ovf_cnt,
  output wused_t                 hwm
);

  function automatic ovf_cnt_t sat_inc(input ovf_cnt_t v);
    return (v == '1) ? v : v + ovf_cnt_t'(1);
  endfunction

  logic [P_ADR_WIDTH-1:0] last_rd_q, last_rd_d;
  logic [P_ADR_WIDTH-1:0] wused_c;
  wused_t                 wused_q, wused_d;
  wused_t                 hwm_q, hwm_d;
  ovf_cnt_t               ovf_cnt_q, ovf_cnt_d;
  logic                   af_q, af_d;
  logic                   ovf_q, ovf_d;
  logic                   sticky_q, sticky_d;
  logic                   ovf_edge;

  always_comb begin
    overflow  = hdr_full | (wr_addr == last_rd_q);
    // Modular subtraction makes write-pointer wrap-around free.
    wused_c   = wr_addr - last_rd_q - P_ADR_WIDTH'(1);
    ovf_edge  = overflow & ~ovf_q;

    last_rd_d = rddone ? stop_addr : last_rd_q;
    wused_d   = wused_t'(wused_c);
    af_d      = (wused_q >= af_thresh);
    ovf_d     = overflow;

    // A clear coinciding with an event leaves that event in the new value.
    sticky_d  = stat_clr ? overflow : (sticky_q | overflow);
    hwm_d     = stat_clr ? wused_q : wused_max(hwm_q, wused_q);
    ovf_cnt_d = ovf_cnt_q;
    if (stat_clr)
      ovf_cnt_d = ovf_edge ? ovf_cnt_t'(1) : '0;
    else if (ovf_edge)
      ovf_cnt_d = sat_inc(ovf_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_rd_q <= '1;
      wused_q   <= '0;
      af_q      <= 1'b0;
      ovf_q     <= 1'b0;
      sticky_q  <= 1'b0;
      ovf_cnt_q <= '0;
      hwm_q     <= '0;
    end else begin
      last_rd_q <= last_rd_d;
      wused_q   <= wused_d;
      af_q      <= af_d;
      ovf_q     <= ovf_d;
      sticky_q  <= sticky_d;
      ovf_cnt_q <= ovf_cnt_d;
      hwm_q     <= hwm_d;
    end
  end

  assign wused       = wused_q;
  assign almost_full = af_q;
  assign ovf_sticky  = sticky_q;
  assign ovf_cnt     = ovf_cnt_q;
  assign hwm         = hwm_q;

endmodule

// File: rtl/wvb_occupancy_monitor.sv
// Multi-channel waveform-buffer occupancy monitor: one independent
// occupancy channel per buffer plus the any-channel summary flags.
module wvb_occupancy_monitor
  import wvb_occupancy_monitor_pkg::*;
#(
  parameter int P_N_CHAN    = 8,
  parameter int P_ADR_WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  wvb_occupancy_monitor_if.slave bus
);

  localparam int WW = L_WVB_WUSED_WIDTH;
  localparam int CW = L_OVF_CNT_WIDTH;

  logic [P_N_CHAN-1:0]    ovf_v;
  logic [P_N_CHAN-1:0]    af_v;
  logic [P_N_CHAN-1:0]    sticky_v;
  logic [P_N_CHAN*WW-1:0] wused_v;
  logic [P_N_CHAN*CW-1:0] cnt_v;
  logic [P_N_CHAN*WW-1:0] hwm_v;

  for (genvar i = 0; i < P_N_CHAN; i++) begin : g_chan
    wvb_occupancy_chan #(
      .P_ADR_WIDTH (P_ADR_WIDTH)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .wr_addr     (bus.wvb_wr_addr[i*P_ADR_WIDTH +: P_ADR_WIDTH]),
      .stop_addr   (bus.stop_addr[i*P_ADR_WIDTH +: P_ADR_WIDTH]),
      .rddone      (bus.wvb_rddone[i]),
      .hdr_full    (bus.hdr_full[i]),
      .af_thresh   (bus.af_thresh),
      .stat_clr    (bus.stat_clr),
      .overflow    (ovf_v[i]),
      .wused       (wused_v[i*WW +: WW]),
      .almost_full (af_v[i]),
      .ovf_sticky  (sticky_v[i]),
      .ovf_cnt     (cnt_v[i*CW +: CW]),
      .hwm         (hwm_v[i*WW +: WW])
    );
  end

  assign bus.overflow        = ovf_v;
  assign bus.overflow_any    = |ovf_v;
  assign bus.wvb_wused       = wused_v;
  assign bus.almost_full     = af_v;
  assign bus.almost_full_any = |af_v;
  assign bus.ovf_sticky      = sticky_v;
  assign bus.ovf_cnt         = cnt_v;
  assign bus.hwm             = hwm_v;

endmodule

// File: tb/tb_wvb_occupancy_monitor.sv
// Bench for wvb_occupancy_monitor: directed scenarios then random traffic,
// all compared against an integer-arithmetic reference of the channel rules.
module tb_wvb_occupancy_monitor;

  localparam int N = 8;
  localparam int A = 12;
  localparam int M = 1 << A;
  localparam int W = N * 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wvb_occupancy_monitor_if #(.P_N_CHAN(N), .P_ADR_WIDTH(A)) bus ();

  wvb_occupancy_monitor #(.P_N_CHAN(N), .P_ADR_WIDTH(A)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [A-1:0] wr [N];
  logic [A-1:0] sa [N];
  logic         rd [N];
  logic         hf [N];
  logic [15:0]  thr;
  logic         clr;

  int m_last [N], m_wused [N], m_af [N], m_sticky [N], m_cnt [N], m_hwm [N], m_prev [N];

  int checks = 0;
  int errors = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int occ(input int w, input int l);
    return ((w - l - 1) % M + M) % M;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_last[c] = M - 1; m_wused[c] = 0; m_af[c] = 0; m_sticky[c] = 0;
      m_cnt[c] = 0; m_hwm[c] = 0; m_prev[c] = 0;
    end
  endtask

  task automatic drive();
    for (int c = 0; c < N; c++) begin
      bus.wvb_wr_addr[c*A +: A] = wr[c];
      bus.stop_addr[c*A +: A]   = sa[c];
      bus.wvb_rddone[c]         = rd[c];
      bus.hdr_full[c]           = hf[c];
    end
    bus.af_thresh = thr;
    bus.stat_clr  = clr;
  endtask

  task automatic cycle();
    logic [N-1:0] eo;
    logic [W-1:0] ew, ec, eh;
    logic [N-1:0] ea, es;
    int n_last [N], n_wused [N], n_af [N], n_st [N], n_cnt [N], n_hwm [N], n_prev [N];
    drive();
    #1;
    for (int c = 0; c < N; c++) eo[c] = hf[c] || (int'(wr[c]) == m_last[c]);
    chk("overflow", W'(bus.overflow), W'(eo));
    chk("overflow_any", W'(bus.overflow_any), W'(|eo));
    for (int c = 0; c < N; c++) begin
      if (rst) begin
        n_last[c] = M - 1; n_wused[c] = 0; n_af[c] = 0; n_st[c] = 0;
        n_cnt[c] = 0; n_hwm[c] = 0; n_prev[c] = 0;
      end else begin
        bit ev;
        ev         = eo[c] && (m_prev[c] == 0);
        n_last[c]  = rd[c] ? int'(sa[c]) : m_last[c];
        n_wused[c] = occ(int'(wr[c]), m_last[c]);
        n_af[c]    = (m_wused[c] >= int'(thr)) ? 1 : 0;
        n_prev[c]  = eo[c] ? 1 : 0;
        if (clr) begin
          n_st[c]  = eo[c] ? 1 : 0;
          n_cnt[c] = ev ? 1 : 0;
          n_hwm[c] = m_wused[c];
        end else begin
          n_st[c]  = (m_sticky[c] != 0 || eo[c]) ? 1 : 0;
          n_cnt[c] = ev ? ((m_cnt[c] < 65535) ? m_cnt[c] + 1 : 65535) : m_cnt[c];
          n_hwm[c] = (m_wused[c] > m_hwm[c]) ? m_wused[c] : m_hwm[c];
        end
      end
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < N; c++) begin
      m_last[c] = n_last[c]; m_wused[c] = n_wused[c]; m_af[c] = n_af[c];
      m_sticky[c] = n_st[c]; m_cnt[c] = n_cnt[c]; m_hwm[c] = n_hwm[c]; m_prev[c] = n_prev[c];
      ew[c*16 +: 16] = 16'(m_wused[c]);
      ec[c*16 +: 16] = 16'(m_cnt[c]);
      eh[c*16 +: 16] = 16'(m_hwm[c]);
      ea[c] = (m_af[c] != 0);
      es[c] = (m_sticky[c] != 0);
    end
    chk("wvb_wused", W'(bus.wvb_wused), ew);
    chk("almost_full", W'(bus.almost_full), W'(ea));
    chk("almost_full_any", W'(bus.almost_full_any), W'(|ea));
    chk("ovf_sticky", W'(bus.ovf_sticky), W'(es));
    chk("ovf_cnt", W'(bus.ovf_cnt), ec);
    chk("hwm", W'(bus.hwm), eh);
  endtask

  initial begin
    for (int c = 0; c < N; c++) begin
      wr[c] = '0; sa[c] = '0; rd[c] = 1'b0; hf[c] = 1'b0;
    end
    thr = 16'd3000;
    clr = 1'b0;
    rst = 1'b1;
    drive();
    @(posedge clk);
    #1;
    model_reset();

    // Reset state, then probe the reset read pointer via overflow on ch0
    repeat (2) cycle();
    wr[0] = 12'hFFF;
    cycle();
    chk("reset_last_rd_probe", W'(bus.overflow[0]), W'(1'b1));
    wr[0] = '0;
    cycle();
    rst = 1'b0;

    // Fill and read on channel 2
    wr[2] = 12'd100;
    cycle();
    chk("fill_wused_100", W'(bus.wvb_wused[2*16 +: 16]), W'(16'd100));
    rd[2] = 1'b1; sa[2] = 12'd49;
    cycle();
    rd[2] = 1'b0;
    cycle();
    chk("read_wused_50", W'(bus.wvb_wused[2*16 +: 16]), W'(16'd50));
    chk("other_chan_wused", W'(bus.wvb_wused[1*16 +: 16]), W'(16'd0));

    // Wrap-around on channel 3
    rd[3] = 1'b1; sa[3] = 12'd4000; wr[3] = 12'd10;
    cycle();
    rd[3] = 1'b0;
    cycle();
    chk("wrap_wused_105", W'(bus.wvb_wused[3*16 +: 16]), W'(16'd105));
    cycle();

    // Overflow excursions on channel 4, header-full on channel 5
    rd[4] = 1'b1; sa[4] = 12'd500; wr[4] = 12'd400;
    cycle();
    rd[4] = 1'b0;
    cycle();
    wr[4] = 12'd500;
    repeat (3) cycle();
    wr[4] = 12'd501;
    repeat (2) cycle();
    chk("ovf_cnt_one", W'(bus.ovf_cnt[4*16 +: 16]), W'(16'd1));
    chk("ovf_sticky_set", W'(bus.ovf_sticky[4]), W'(1'b1));
    wr[4] = 12'd500;
    cycle();
    wr[4] = 12'd501;
    repeat (2) cycle();
    chk("ovf_cnt_two", W'(bus.ovf_cnt[4*16 +: 16]), W'(16'd2));
    hf[5] = 1'b1;
    cycle();
    hf[5] = 1'b0;
    cycle();

    // Almost-full threshold and high-water mark on channel 6
    wr[6] = 12'd2999;
    repeat (2) cycle();
    chk("af_below", W'(bus.almost_full[6]), W'(1'b0));
    wr[6] = 12'd3000;
    cycle();
    chk("af_lag", W'(bus.almost_full[6]), W'(1'b0));
    cycle();
    chk("af_rise", W'(bus.almost_full[6]), W'(1'b1));
    cycle();
    rd[6] = 1'b1; sa[6] = 12'd2989;
    cycle();
    rd[6] = 1'b0;
    repeat (3) cycle();
    chk("hwm_hold_3000", W'(bus.hwm[6*16 +: 16]), W'(16'd3000));
    chk("wused_10", W'(bus.wvb_wused[6*16 +: 16]), W'(16'd10));

    // Clear coinciding with an overflow rising edge
    wr[4] = 12'd500; clr = 1'b1;
    cycle();
    clr = 1'b0;
    chk("clr_cnt_one", W'(bus.ovf_cnt[4*16 +: 16]), W'(16'd1));
    chk("clr_sticky_one", W'(bus.ovf_sticky[4]), W'(1'b1));
    chk("clr_hwm_current", W'(bus.hwm[6*16 +: 16]), W'(16'd10));
    wr[4] = 12'd501;
    repeat (2) cycle();

    // Counter saturation: preload near the top, then drive further edges
    force dut.g_chan[4].u_chan.ovf_cnt_q = 16'hFFFD;
    #1;
    release dut.g_chan[4].u_chan.ovf_cnt_q;
    m_cnt[4] = 65533;
    repeat (3) begin
      wr[4] = 12'd500;
      cycle();
      wr[4] = 12'd501;
      cycle();
    end
    chk("ovf_cnt_saturated", W'(bus.ovf_cnt[4*16 +: 16]), W'(16'hFFFF));

    // Random traffic, including mid-run resets and clears
    repeat (400) begin
      rst = ($urandom_range(0, 49) == 0);
      clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 4))
          0: thr = 16'd0;
          1: thr = 16'd5000;
          2: thr = 16'hFFFF;
          default: thr = 16'($urandom_range(0, M - 1));
        endcase
      end
      for (int c = 0; c < N; c++) begin
        case ($urandom_range(0, 3))
          0: wr[c] = A'(m_last[c]);
          1: wr[c] = A'(m_last[c] + 1);
          default: wr[c] = A'($urandom_range(0, M - 1));
        endcase
        rd[c] = ($urandom_range(0, 5) == 0);
        sa[c] = A'($urandom_range(0, M - 1));
        hf[c] = ($urandom_range(0, 15) == 0);
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
